// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decodes the RV32I/RV64I immediate format, sign-extends
// to XLEN and queues the result in a 2-entry skid FIFO; tallies illegal formats.
module imm_gen_stage #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // the producer holds its payload while valid && !ready.

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_Z = 3'b101;
    localparam logic [2:0] FMT_R = 3'b110;
    localparam logic [2:0] FMT_X = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    logic [2:0]  auto_fmt;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    entry_t      new_entry;
    logic        unused_instr_bits;

    entry_t           mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // funct3 bits other than instr[14] never influence the immediate.
    assign unused_instr_bits = ^instr[13:12];

    always_comb begin
        auto_fmt = FMT_X;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: auto_fmt = FMT_I;
            7'b1110011:                         auto_fmt = instr[14] ? FMT_Z : FMT_I;
            7'b0100011:                         auto_fmt = FMT_S;
            7'b1100011:                         auto_fmt = FMT_B;
            7'b1101111:                         auto_fmt = FMT_J;
            7'b0110111, 7'b0010111:             auto_fmt = FMT_U;
            7'b0110011:                         auto_fmt = FMT_R;
            default:                            auto_fmt = FMT_X;
        endcase
    end

    assign fmt = (AUTO_DECODE != 0) ? auto_fmt : imm_src;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_Z: imm32 = {27'b0, instr[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Every format's bit 31 is already its sign (zero for Z/R/illegal), so one widening
    // cast covers the XLEN=64 extension, including U.
    always_comb begin
        new_entry     = '0;
        new_entry.imm = XLEN'($signed(imm32));
        new_entry.fmt = fmt;
        new_entry.ill = (fmt == FMT_X);
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);
        cnt_d      = cnt_q;
        if (push && new_entry.ill && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign imm_ext     = mem_q[rd_ptr_q].imm;
    assign imm_fmt     = mem_q[rd_ptr_q].fmt;
    assign illegal     = mem_q[rd_ptr_q].ill;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three parameterisations share stimulus; an arithmetic
// reference model feeds a scoreboard queue that a negedge monitor drains.
module tb_imm_gen_stage;

    typedef struct packed {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] em;
        logic [2:0]  fmtm;
        logic        illm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  imm_src = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [7:0]  cnt_a;
    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [1:0]  cnt_b;
    logic        in_ready_c, out_valid_c, illegal_c;
    logic [31:0] imm_c;
    logic [2:0]  fmt_c;
    logic [7:0]  cnt_c;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   occ      = 0;
    int   mcnt_a   = 0;
    int   mcnt_b   = 0;
    int   mcnt_c   = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm_ext(imm_a), .imm_fmt(fmt_a), .illegal(illegal_a), .illegal_cnt(cnt_a));

    imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm_ext(imm_b), .imm_fmt(fmt_b), .illegal(illegal_b), .illegal_cnt(cnt_b));

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid_c), .out_ready(out_ready),
        .imm_ext(imm_c), .imm_fmt(fmt_c), .illegal(illegal_c), .illegal_cnt(cnt_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint x, input int bits);
        return (x <<< (64 - bits)) >>> (64 - bits);
    endfunction

    // Reference: field positions straight from the ISA immediate tables.
    function automatic void ref_model(input logic [31:0] ins, input logic [2:0] src,
                                      input bit auto_dec, output logic [2:0] f,
                                      output longint v);
        longint x;
        int     op;
        x  = longint'(ins);
        op = int'(ins[6:0]);
        if (auto_dec) begin
            if (op == 'h03 || op == 'h13 || op == 'h67) f = 3'd0;
            else if (op == 'h73) f = ins[14] ? 3'd5 : 3'd0;
            else if (op == 'h23) f = 3'd1;
            else if (op == 'h63) f = 3'd2;
            else if (op == 'h6F) f = 3'd3;
            else if (op == 'h37 || op == 'h17) f = 3'd4;
            else if (op == 'h33) f = 3'd6;
            else f = 3'd7;
        end else begin
            f = src;
        end
        case (f)
            3'd0: v = sext(x >> 20, 12);
            3'd1: v = sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
            3'd2: v = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                           (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
            3'd3: v = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                           (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
            3'd4: v = sext(x & 'hFFFFF000, 32);
            3'd5: v = (x >> 15) & 31;
            default: v = 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23,
                                  7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    // Called at posedge+1: drives one cycle of inputs and advances the model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] src,
                        input bit ordy);
        bit          acc, pp;
        exp_t        e;
        logic [2:0]  fa, fc;
        longint      va, vc;
        in_valid  = v;
        instr     = ins;
        imm_src   = src;
        out_ready = ordy;
        acc = v && (occ < 2);
        pp  = (occ > 0) && ordy;
        if (acc) begin
            ref_model(ins, src, 1'b1, fa, va);
            ref_model(ins, src, 1'b0, fc, vc);
            e.e32  = va[31:0];
            e.e64  = va;
            e.fmt  = fa;
            e.ill  = (fa == 3'd7);
            e.em   = vc[31:0];
            e.fmtm = fc;
            e.illm = (fc == 3'd7);
            exp_q.push_back(e);
            if (e.ill) begin
                if (mcnt_a < 255) mcnt_a++;
                if (mcnt_b < 3) mcnt_b++;
            end
            if (e.illm && mcnt_c < 255) mcnt_c++;
        end
        @(posedge clk);
        #1;
        occ = occ + int'(acc) - int'(pp);
        chk("in_ready_a", in_ready_a, occ < 2);
        chk("in_ready_b", in_ready_b, occ < 2);
        chk("in_ready_c", in_ready_c, occ < 2);
        chk("out_valid_a", out_valid_a, occ > 0);
        chk("out_valid_b", out_valid_b, occ > 0);
        chk("out_valid_c", out_valid_c, occ > 0);
        chk("illegal_cnt_a", cnt_a, mcnt_a);
        chk("illegal_cnt_b", cnt_b, mcnt_b);
        chk("illegal_cnt_c", cnt_c, mcnt_c);
    endtask

    task automatic reset_midburst();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_imm", imm_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_cnt_c", cnt_c, 0);
        exp_q.delete();
        occ = 0; mcnt_a = 0; mcnt_b = 0; mcnt_c = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready_a, 1'b1);
        chk("post_rst_out_valid", out_valid_a, 1'b0);
    endtask

    // Monitor: while an output is presented it must equal the queue head; pop on transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid_a) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("imm32", imm_a, e.e32);
                    chk("fmt32", fmt_a, e.fmt);
                    chk("ill32", illegal_a, e.ill);
                    chk("imm64", imm_b, e.e64);
                    chk("fmt64", fmt_b, e.fmt);
                    chk("ill64", illegal_b, e.ill);
                    chk("imm_man", imm_c, e.em);
                    chk("fmt_man", fmt_c, e.fmtm);
                    chk("ill_man", illegal_c, e.illm);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dir_vec [7] = '{32'hFFF00093, 32'hFE112E23, 32'h0010006F, 32'h123450B7,
                                     32'h800000B7, 32'h0000007F, 32'h00A7D073};
        logic [2:0]  dir_src [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd7, 3'd5};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready_a, 1'b0);
        chk("reset_out_valid", out_valid_a, 1'b0);
        chk("reset_imm", imm_a, 0);
        chk("reset_fmt", fmt_a, 0);
        chk("reset_illegal", illegal_a, 0);
        chk("reset_cnt", cnt_a, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("release_in_ready", in_ready_a, 1'b1);

        for (int i = 0; i < 7; i++) step(1'b1, dir_vec[i], dir_src[i], 1'b1);
        repeat (2) step(1'b0, '0, '0, 1'b1);

        // Five illegal entries: the 2-bit counter must stop at 3.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000007F, 3'd7, 1'b1);
        repeat (2) step(1'b0, '0, '0, 1'b1);

        // Back-pressure: A, B fill the FIFO, C waits, then drains without bubbles.
        step(1'b1, 32'hFFF00093, 3'd0, 1'b0);
        step(1'b1, 32'hFE112E23, 3'd1, 1'b0);
        step(1'b1, 32'h0010006F, 3'd3, 1'b0);
        step(1'b1, 32'h0010006F, 3'd3, 1'b0);
        step(1'b1, 32'h0010006F, 3'd3, 1'b1);
        step(1'b1, 32'h0010006F, 3'd3, 1'b1);
        repeat (3) step(1'b0, '0, '0, 1'b1);

        // Reset with two entries queued.
        step(1'b1, 32'h123450B7, 3'd4, 1'b0);
        step(1'b1, 32'h0000007F, 3'd7, 1'b0);
        reset_midburst();

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7);
        end
        repeat (4) step(1'b0, '0, '0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
